maple_rx_controller: RTL and testbench

MAPLE_RX_CONTROLLER -- requirements
Module: maple_rx_controller

---
 rtl/maple_rx_controller.sv | 178 +++++++++++++++++
 tb/tb_maple_rx_controller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/maple_rx_controller.sv
// Maple bus receive frame controller: start/end pattern detection, header capture,
// payload streaming, checksum and timeout. Optional MAPLE_RX_CKSUM_CHECK_EN enables checksum compare.
module maple_rx_controller #(
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sdcka_data,
  input  logic       sdcka_posedge,
  input  logic       sdcka_negedge,
  input  logic       sdckb_data,
  input  logic       sdckb_posedge,
  input  logic       sdckb_negedge,
  input  logic [7:0] dec_data,
  input  logic       dec_ready,
  output logic       dec_reset,
  output logic [7:0] hdr_len,
  output logic [7:0] hdr_src,
  output logic [7:0] hdr_dst,
  output logic [7:0] hdr_cmd,
  output logic [7:0] pl_data,
  output logic       pl_valid,
  output logic       busy,
  output logic       frame_done,
  output logic [1:0] err_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_CKSUM,
    S_END_WAIT
  } state_t;

  state_t      state, state_next;
  logic [2:0]  start_cnt;
  logic [1:0]  end_cnt;
  logic [10:0] byte_cnt;
  logic [19:0] tmo_cnt;
  logic [10:0] pl_total;
  logic [1:0]  cksum_code;
  logic        start_det, end_det, tmo_hit;
  logic        frame_start, done, take_hdr, take_pl;
  logic [1:0]  done_err;

  // Line levels are not needed: the edge strobes carry all pattern information.
  logic unused_levels;
  assign unused_levels = sdcka_data ^ sdckb_data;

  assign start_det = sdcka_posedge && (start_cnt >= 3'd4);
  assign end_det   = sdckb_posedge && (end_cnt == 2'd2);
  assign tmo_hit   = (tmo_cnt == TIMEOUT_CYCLES - 20'd1);
  assign pl_total  = {1'b0, hdr_len, 2'b00};
  assign busy      = (state != S_IDLE);

`ifdef MAPLE_RX_CKSUM_CHECK_EN
  logic [7:0] acc;
  logic       cksum_bad;
  logic       take_ck;
  assign take_ck    = (state == S_CKSUM) && dec_ready && !start_det && !end_det;
  assign cksum_code = cksum_bad ? 2'b01 : 2'b00;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      cksum_bad <= 1'b0;
    end else begin
      if (frame_start)            acc <= '0;
      else if (take_hdr || take_pl) acc <= acc ^ dec_data;
      if (frame_start)  cksum_bad <= 1'b0;
      else if (take_ck) cksum_bad <= (dec_data != acc);
    end
  end
`else
  assign cksum_code = 2'b00;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Priority per cycle: start pattern, end pattern, decoder byte, timeout.
  always_comb begin
    state_next  = state;
    frame_start = 1'b0;
    done        = 1'b0;
    done_err    = 2'b00;
    take_hdr    = 1'b0;
    take_pl     = 1'b0;
    if (start_det) begin
      frame_start = 1'b1;
      state_next  = S_HEADER;
      if (state != S_IDLE) begin
        done     = 1'b1;
        done_err = 2'b10;
      end
    end else if (state != S_IDLE) begin
      if (end_det) begin
        done       = 1'b1;
        done_err   = (state == S_END_WAIT) ? cksum_code : 2'b10;
        state_next = S_IDLE;
      end else if (dec_ready) begin
        unique case (state)
          S_HEADER: begin
            take_hdr = 1'b1;
            if (byte_cnt[1:0] == 2'd3)
              state_next = (hdr_len == 8'd0) ? S_CKSUM : S_PAYLOAD;
          end
          S_PAYLOAD: begin
            take_pl = 1'b1;
            if (byte_cnt + 11'd1 == pl_total) state_next = S_CKSUM;
          end
          S_CKSUM: state_next = S_END_WAIT;
          S_END_WAIT: begin
            done       = 1'b1;
            done_err   = 2'b10;
            state_next = S_IDLE;
          end
          default: state_next = S_IDLE;
        endcase
      end else if (tmo_hit) begin
        done       = 1'b1;
        done_err   = 2'b11;
        state_next = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dec_reset  <= 1'b0;
      pl_valid   <= 1'b0;
      pl_data    <= '0;
      frame_done <= 1'b0;
      err_code   <= '0;
      hdr_len    <= '0;
      hdr_src    <= '0;
      hdr_dst    <= '0;
      hdr_cmd    <= '0;
      start_cnt  <= '0;
      end_cnt    <= '0;
      byte_cnt   <= '0;
      tmo_cnt    <= '0;
    end else begin
      dec_reset  <= frame_start;
      pl_valid   <= take_pl;
      frame_done <= done;
      if (done) err_code <= done_err;

      if (start_det || sdcka_negedge)                start_cnt <= '0;
      else if (sdckb_negedge && start_cnt < 3'd4)   start_cnt <= start_cnt + 3'd1;

      if (end_det || sdckb_negedge)                 end_cnt <= '0;
      else if (sdcka_negedge && end_cnt < 2'd2)     end_cnt <= end_cnt + 2'd1;

      // Counter restarts at zero when the header completes so it counts payload bytes only.
      if (frame_start)                              byte_cnt <= '0;
      else if (take_hdr && byte_cnt[1:0] == 2'd3)   byte_cnt <= '0;
      else if (take_hdr || take_pl)                 byte_cnt <= byte_cnt + 11'd1;

      if (frame_start || dec_ready || state == S_IDLE) tmo_cnt <= '0;
      else                                             tmo_cnt <= tmo_cnt + 20'd1;

      if (take_hdr) begin
        unique case (byte_cnt[1:0])
          2'd0: hdr_len <= dec_data;
          2'd1: hdr_src <= dec_data;
          2'd2: hdr_dst <= dec_data;
          default: hdr_cmd <= dec_data;
        endcase
      end
      if (take_pl) pl_data <= dec_data;
    end
  end

endmodule

// File: tb/tb_maple_rx_controller.sv
// Directed self-checking bench for maple_rx_controller (TIMEOUT_CYCLES reduced to 100).
module tb_maple_rx_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sdcka_data = 1'b1, sdcka_posedge = 1'b0, sdcka_negedge = 1'b0;
  logic       sdckb_data = 1'b1, sdckb_posedge = 1'b0, sdckb_negedge = 1'b0;
  logic [7:0] dec_data = '0;
  logic       dec_ready = 1'b0;
  logic       dec_reset, pl_valid, busy, frame_done;
  logic [7:0] hdr_len, hdr_src, hdr_dst, hdr_cmd, pl_data;
  logic [1:0] err_code;

  int compared = 0;
  int mismatched = 0;
  int pl_count = 0;
  int done_count = 0;
  int p0, d0;

`ifdef MAPLE_RX_CKSUM_CHECK_EN
  localparam logic [1:0] BAD_CK_ERR = 2'b01;
`else
  localparam logic [1:0] BAD_CK_ERR = 2'b00;
`endif

  maple_rx_controller #(.TIMEOUT_CYCLES(20'd100)) dut (
    .clk(clk), .reset(reset),
    .sdcka_data(sdcka_data), .sdcka_posedge(sdcka_posedge), .sdcka_negedge(sdcka_negedge),
    .sdckb_data(sdckb_data), .sdckb_posedge(sdckb_posedge), .sdckb_negedge(sdckb_negedge),
    .dec_data(dec_data), .dec_ready(dec_ready), .dec_reset(dec_reset),
    .hdr_len(hdr_len), .hdr_src(hdr_src), .hdr_dst(hdr_dst), .hdr_cmd(hdr_cmd),
    .pl_data(pl_data), .pl_valid(pl_valid), .busy(busy),
    .frame_done(frame_done), .err_code(err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pl_valid)   pl_count++;
    if (frame_done) done_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic a_neg(); sdcka_data = 1'b0; sdcka_negedge = 1'b1; tick(); sdcka_negedge = 1'b0; endtask
  task automatic a_pos(); sdcka_data = 1'b1; sdcka_posedge = 1'b1; tick(); sdcka_posedge = 1'b0; endtask
  task automatic b_neg(); sdckb_data = 1'b0; sdckb_negedge = 1'b1; tick(); sdckb_negedge = 1'b0; sdckb_data = 1'b1; endtask
  task automatic b_pos(); sdckb_data = 1'b1; sdckb_posedge = 1'b1; tick(); sdckb_posedge = 1'b0; endtask

  task automatic send_start(); repeat (4) b_neg(); a_pos(); endtask
  task automatic send_end();   repeat (2) a_neg(); b_pos(); endtask

  task automatic send_byte(input logic [7:0] b);
    dec_data = b; dec_ready = 1'b1; tick(); dec_ready = 1'b0;
  endtask

  task automatic pay(input string tag, input logic [7:0] b);
    send_byte(b);
    check({tag, "_valid"}, pl_valid, 1);
    check({tag, "_data"}, pl_data, b);
  endtask

  initial begin
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_decrst", dec_reset, 0);
    check("rst_plvalid", pl_valid, 0);
    check("rst_outs", {err_code, pl_data, hdr_len, hdr_src, hdr_dst, hdr_cmd}, 0);
    reset = 1'b0;
    tick();

    // Only three SDCKB falls: not a start pattern.
    repeat (3) b_neg();
    a_pos();
    check("short_start_decrst", dec_reset, 0);
    check("short_start_busy", busy, 0);
    tick();
    check("short_start_busy2", busy, 0);

    // Good frame; checksum is XOR of all header and payload bytes = 0x64.
    send_start();
    check("start_decrst", dec_reset, 1);
    check("start_busy", busy, 1);
    tick();
    check("decrst_one_cycle", dec_reset, 0);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h20); send_byte(8'h01);
    check("hdr_no_plvalid", pl_valid, 0);
    p0 = pl_count;
    pay("pl0", 8'h11); pay("pl1", 8'h22); pay("pl2", 8'h33); pay("pl3", 8'h44);
    send_byte(8'h64);
    check("cksum_not_payload", pl_valid, 0);
    check("cksum_busy", busy, 1);
    d0 = done_count;
    send_end();
    check("ok_done", frame_done, 1);
    check("ok_err", err_code, 2'b00);
    check("ok_hdr_len", hdr_len, 8'h01);
    check("ok_hdr_src", hdr_src, 8'h00);
    check("ok_hdr_dst", hdr_dst, 8'h20);
    check("ok_hdr_cmd", hdr_cmd, 8'h01);
    tick();
    check("ok_done_one_cycle", frame_done, 0);
    check("ok_idle", busy, 0);
    check("ok_err_hold", err_code, 2'b00);
    check("ok_pl_count", pl_count - p0, 4);
    check("ok_done_count", done_count - d0, 1);

    // Same frame, wrong checksum.
    send_start();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h20); send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h00);
    send_end();
    check("badck_done", frame_done, 1);
    check("badck_err", err_code, BAD_CK_ERR);
    tick();

    // len=2 but end pattern after 4 payload bytes.
    send_start();
    send_byte(8'h02); send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h0C);
    p0 = pl_count;
    pay("short0", 8'hA1); pay("short1", 8'hA2); pay("short2", 8'hA3); pay("short3", 8'hA4);
    send_end();
    check("short_done", frame_done, 1);
    check("short_err", err_code, 2'b10);
    tick();
    check("short_pl_count", pl_count - p0, 4);
    check("short_idle", busy, 0);

    // Start pattern mid-header abandons the frame and restarts.
    send_start();
    send_byte(8'h01); send_byte(8'h02);
    send_start();
    check("restart_done", frame_done, 1);
    check("restart_err", err_code, 2'b10);
    check("restart_decrst", dec_reset, 1);
    check("restart_busy", busy, 1);
    send_end();
    check("hdr_end_done", frame_done, 1);
    check("hdr_end_err", err_code, 2'b10);
    tick();
    check("hdr_end_idle", busy, 0);

    // Extra byte while waiting for the end pattern.
    send_start();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    send_byte(8'h00);
    check("endwait_busy", busy, 1);
    send_byte(8'h55);
    check("endwait_byte_done", frame_done, 1);
    check("endwait_byte_err", err_code, 2'b10);
    tick();

    // Timeout 100 cycles after the only header byte.
    send_start();
    send_byte(8'h05);
    d0 = done_count;
    repeat (99) tick();
    check("tmo_not_early", frame_done, 0);
    check("tmo_no_pulse_early", done_count - d0, 0);
    tick();
    check("tmo_done", frame_done, 1);
    check("tmo_err", err_code, 2'b11);
    tick();
    check("tmo_idle", busy, 0);

    // Reset mid-payload, coinciding with a decoder strobe.
    send_start();
    send_byte(8'h03); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    send_byte(8'hD1); send_byte(8'hD2);
    d0 = done_count;
    reset = 1'b1; dec_data = 8'h77; dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    check("rst_mid_plvalid", pl_valid, 0);
    check("rst_mid_done", frame_done, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_err", err_code, 2'b00);
    reset = 1'b0;
    tick();
    send_start();
    send_byte(8'h00); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    send_byte(8'h70);
    send_end();
    check("len0_done", frame_done, 1);
    check("len0_err", err_code, 2'b00);
    check("len0_hdr", {hdr_len, hdr_src, hdr_dst, hdr_cmd}, 32'h00123456);
    tick();
    check("len0_done_count", done_count - d0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
